reg_wb_ctrl: RTL
================

Name: reg_wb_ctrl

Overview:
Write-side controller for the 4-entry, 8-bit register file. It takes writeback traffic from the ALU and the memory-load return path and merges it onto the single register-file write port (wr_en/wr_sel/wr_data). Load returns go through a small FIFO. A per-register pending scoreboard lets the issue stage stall reads of registers whose load is still outstanding.

Parameters:
DATA_W, 8, register/data width
SEL_W, 2, register select width (2^SEL_W registers)
DEPTH, 2, load-return FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on posedge
reset_  in  1  asynchronous active-low reset
alu_wb_valid  in  1  ALU writeback this cycle; always accepted, no ready
alu_wb_sel  in  SEL_W  ALU destination register
alu_wb_data  in  DATA_W  ALU result
ld_issue_valid  in  1  load issued; marks destination pending
ld_issue_sel  in  SEL_W  load destination register
ld_wb_valid  in  1  load return data valid
ld_wb_ready  out  1  load return accepted when valid&ready
ld_wb_sel  in  SEL_W  load return destination
ld_wb_data  in  DATA_W  load return data
chk_sel_0  in  SEL_W  issue-stage hazard query 0
chk_sel_1  in  SEL_W  issue-stage hazard query 1
chk_busy_0  out  1  register chk_sel_0 has an uncommitted load
chk_busy_1  out  1  register chk_sel_1 has an uncommitted load
wr_en  out  1  register-file write enable (registered)
wr_sel  out  SEL_W  register-file write select (registered)
wr_data  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (async, reset_=0): wr_en=0, wr_sel=0, wr_data=0, FIFO empty (count=0, pointers 0), all pending bits 0. ld_wb_ready=1 during and after reset; chk_busy_*=0.
- Load FIFO: push on ld_wb_valid & ld_wb_ready. ld_wb_ready = (count != DEPTH), combinational from registered count. When full, ready=0 even if a pop occurs the same cycle; no fall-through. Pointers wrap modulo DEPTH.
- Arbitration, evaluated each cycle:
  - alu_wb_valid=1: ALU wins. Next cycle wr_en=1, wr_sel=alu_wb_sel, wr_data=alu_wb_data. No FIFO pop.
  - alu_wb_valid=0 and FIFO non-empty: pop the head. Next cycle wr_en=1 with the head sel/data, and this commit is flagged as a load commit (internal registered flag).
  - Otherwise: next cycle wr_en=0; wr_sel/wr_data hold their previous values.
- Latency: an ALU writeback reaches wr_* 1 cycle after it is presented. A load return pushed into an empty FIFO with no ALU traffic is popped the following cycle and reaches wr_* 2 cycles after acceptance.
- ALU priority is strict. Sustained ALU traffic may hold the FIFO indefinitely; this is permitted.
- A push and a pop in the same cycle leave count unchanged. Entry order is strictly FIFO.
- Scoreboard, pending[N]:
  - Set at posedge when ld_issue_valid for ld_issue_sel.
  - Cleared at posedge after the cycle in which wr_en=1 with a load commit for that register.
  - Set and clear of the same register in the same cycle: set wins.
- chk_busy_k = pending[chk_sel_k] & ~(wr_en & load_commit & wr_sel==chk_sel_k). This is combinational; it clears in the commit cycle because the register file bypasses wr_data to same-cycle reads.
- Illegal, flagged by bench assertions only (no RTL handling):
  - ld_issue to a pending register.
  - ALU writeback to a pending register.
  - ld_wb return for a non-pending register.
  - More outstanding loads than DEPTH+pipeline depth. Returns are throttled by ready only.
- Reset asserted mid-operation: FIFO contents and pending bits are discarded immediately, and wr_en drops asynchronously.

Test Plan:
- Reset, then idle 5 cycles -> wr_en=0, ld_wb_ready=1, chk_busy_0/1=0 throughout.
- ALU valid sel=2 data=0x5A for 1 cycle -> next cycle wr_en=1 wr_sel=2 wr_data=0x5A, then wr_en=0.
- ld_issue sel=1; 3 cycles later ld_wb sel=1 data=0xC3 with no ALU -> chk_busy(1)=1 from the cycle after issue; wr_en=1 sel=1 data=0xC3 two cycles after the return; chk_busy(1)=0 in that same cycle and stays 0.
- FIFO full: issue loads to r0,r1, return both while ALU valid every cycle (targets r2/r3) -> after 2 pushes ld_wb_ready=0; when ALU stops, commits r0 then r1 in order, and ready returns to 1 after the first pop.
- Simultaneous push/pop at count=1: ALU idle, new return pushed while head popped -> count stays 1, the head is written, and the new entry is written the next cycle.
- Reset asserted with 2 entries queued and pending={r0,r1} -> wr_en=0 immediately; after release no writes occur, ready=1, busy=0.

Source files
------------

// File: rtl/reg_wb_ctrl.sv
// Merges ALU and load-return writebacks onto the register-file write port, and tracks which registers have a load outstanding.
// Latency: 1 cycle for ALU results, 2 for a load return into an empty FIFO. Backpressure: ld_wb_ready drops only when the FIFO is full; the ALU is never stalled.
module reg_wb_ctrl #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              alu_wb_valid,
    input  logic [SEL_W-1:0]  alu_wb_sel,
    input  logic [DATA_W-1:0] alu_wb_data,
    input  logic              ld_issue_valid,
    input  logic [SEL_W-1:0]  ld_issue_sel,
    input  logic              ld_wb_valid,
    output logic              ld_wb_ready,
    input  logic [SEL_W-1:0]  ld_wb_sel,
    input  logic [DATA_W-1:0] ld_wb_data,
    input  logic [SEL_W-1:0]  chk_sel_0,
    input  logic [SEL_W-1:0]  chk_sel_1,
    output logic              chk_busy_0,
    output logic              chk_busy_1,
    output logic              wr_en,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [DATA_W-1:0] wr_data
);

    localparam int NREG  = 1 << SEL_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } ld_ent_t;

    // Load-return FIFO
    ld_ent_t          fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    ld_ent_t          head;
    ld_ent_t          push_ent;

    // Write port and scoreboard
    logic              wr_en_q, wr_en_d;
    logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              ld_commit_q, ld_commit_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic [NREG-1:0]   pend_set;
    logic [NREG-1:0]   pend_clr;
    logic              commit_ld;

    assign fifo_empty    = (cnt_q == '0);
    assign ld_wb_ready   = (cnt_q != CNT_W'(DEPTH));
    assign push          = ld_wb_valid & ld_wb_ready;
    assign pop           = ~alu_wb_valid & ~fifo_empty;
    assign head          = fifo_q[rd_ptr_q];
    assign push_ent.sel  = ld_wb_sel;
    assign push_ent.data = ld_wb_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_ent;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // ALU has strict priority; an idle cycle holds sel/data so the port stays quiet.
    always_comb begin
        wr_en_d     = 1'b0;
        wr_sel_d    = wr_sel_q;
        wr_data_d   = wr_data_q;
        ld_commit_d = 1'b0;
        if (alu_wb_valid) begin
            wr_en_d   = 1'b1;
            wr_sel_d  = alu_wb_sel;
            wr_data_d = alu_wb_data;
        end else if (!fifo_empty) begin
            wr_en_d     = 1'b1;
            wr_sel_d    = head.sel;
            wr_data_d   = head.data;
            ld_commit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_en_q     <= 1'b0;
            wr_sel_q    <= '0;
            wr_data_q   <= '0;
            ld_commit_q <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_sel_q    <= wr_sel_d;
            wr_data_q   <= wr_data_d;
            ld_commit_q <= ld_commit_d;
        end
    end

    assign commit_ld = wr_en_q & ld_commit_q;

    // A new issue to a register overrides the clear from its previous load's commit.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (ld_issue_valid) begin
            pend_set[ld_issue_sel] = 1'b1;
        end
        if (commit_ld) begin
            pend_clr[wr_sel_q] = 1'b1;
        end
        pending_d = (pending_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // The register file bypasses wr_data, so a register is readable in its commit cycle.
    assign chk_busy_0 = pending_q[chk_sel_0] & ~(commit_ld & (wr_sel_q == chk_sel_0));
    assign chk_busy_1 = pending_q[chk_sel_1] & ~(commit_ld & (wr_sel_q == chk_sel_1));

    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_data = wr_data_q;

endmodule
